// File: rtl/pwm_capture_if.sv
// Bus between a PWM source and the pwm_capture block: input waveform plus measurement results.
interface pwm_capture_if #(
   parameter int unsigned CNT_WIDTH = 32
);
   logic                 pwm_in;
   logic [CNT_WIDTH-1:0] period;
   logic [CNT_WIDTH-1:0] high_time;
   logic                 valid;
   logic                 no_signal;
   logic                 level;

   // Source side: drives the waveform, observes the measurement
   modport master (
      output pwm_in,
      input  period,
      input  high_time,
      input  valid,
      input  no_signal,
      input  level
   );

   // Capture side: samples the waveform, reports the measurement
   modport slave (
      input  pwm_in,
      output period,
      output high_time,
      output valid,
      output no_signal,
      output level
   );
endinterface

// File: rtl/pwm_capture.sv
// PWM/tach capture: measures period and high time of each full input cycle in clk cycles,
// and flags loss of signal after TIMEOUT cycles without a rising edge.
module pwm_capture #(
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned TIMEOUT   = 1_000_000
) (
   input  logic         clk,
   input  logic         rst,
   pwm_capture_if.slave bus
);

   localparam logic [1:0] ST_SYNC  = 2'd0;
   localparam logic [1:0] ST_HIGH  = 2'd1;
   localparam logic [1:0] ST_LOW   = 2'd2;
   localparam logic [1:0] ST_NOSIG = 2'd3;

   localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] LP_ONE     = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] LP_ZERO    = CNT_WIDTH'(0);

   logic                 r_s1;
   logic                 r_s2;
   logic                 r_s3;
   logic [1:0]           r_state;
   logic [1:0]           w_state_nxt;
   logic [CNT_WIDTH-1:0] r_pcnt;
   logic [CNT_WIDTH-1:0] r_hcnt;
   logic [CNT_WIDTH-1:0] r_hold_h;
   logic [CNT_WIDTH-1:0] r_period;
   logic [CNT_WIDTH-1:0] r_high_time;
   logic                 r_valid;
   logic                 r_no_signal;

   logic                 w_rise;
   logic                 w_fall;
   logic                 w_pcnt_max;
   logic                 w_capture;
   logic                 w_latch_h;
   logic                 w_enter_nosig;
   logic                 w_leave_nosig;

   assign w_rise     = r_s2 & ~r_s3;
   assign w_fall     = ~r_s2 & r_s3;
   assign w_pcnt_max = (r_pcnt == LP_TIMEOUT);

   // Two-flop synchroniser plus one delay stage for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= bus.pwm_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and datapath strobes; a rise always wins over a coincident timeout
   always_comb begin
      w_state_nxt   = r_state;
      w_capture     = 1'b0;
      w_latch_h     = 1'b0;
      w_enter_nosig = 1'b0;
      w_leave_nosig = 1'b0;
      case (r_state)
         ST_SYNC: begin
            if (w_rise) begin
               w_state_nxt = ST_HIGH;
            end else if (w_pcnt_max) begin
               w_state_nxt   = ST_NOSIG;
               w_enter_nosig = 1'b1;
            end
         end
         ST_HIGH: begin
            if (w_pcnt_max) begin
               w_state_nxt   = ST_NOSIG;
               w_enter_nosig = 1'b1;
            end else if (w_fall) begin
               w_state_nxt = ST_LOW;
               w_latch_h   = 1'b1;
            end
         end
         ST_LOW: begin
            if (w_rise) begin
               w_state_nxt = ST_HIGH;
               w_capture   = 1'b1;
            end else if (w_pcnt_max) begin
               w_state_nxt   = ST_NOSIG;
               w_enter_nosig = 1'b1;
            end
         end
         ST_NOSIG: begin
            if (w_rise) begin
               w_state_nxt   = ST_HIGH;
               w_leave_nosig = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_SYNC;
         end
      endcase
   end

   // Period and high-time counters; both restart at 1 on a rise and saturate at TIMEOUT
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcnt <= LP_ZERO;
         r_hcnt <= LP_ZERO;
      end else begin
         if (w_rise) begin
            r_pcnt <= LP_ONE;
         end else if (!w_pcnt_max) begin
            r_pcnt <= r_pcnt + LP_ONE;
         end
         if (w_rise) begin
            r_hcnt <= LP_ONE;
         end else if ((r_state == ST_HIGH) && (r_hcnt != LP_TIMEOUT)) begin
            r_hcnt <= r_hcnt + LP_ONE;
         end
      end
   end

   // High time is held from the falling edge until the closing rise commits it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_h <= LP_ZERO;
      end else if (w_latch_h) begin
         r_hold_h <= r_hcnt;
      end
   end

   // Result registers: update on capture, clear on loss of signal, hold otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         r_period    <= LP_ZERO;
         r_high_time <= LP_ZERO;
         r_valid     <= 1'b0;
         r_no_signal <= 1'b0;
      end else begin
         r_valid <= w_capture;
         if (w_capture) begin
            r_period    <= r_pcnt;
            r_high_time <= r_hold_h;
         end else if (w_enter_nosig) begin
            r_period    <= LP_ZERO;
            r_high_time <= LP_ZERO;
         end
         if (w_enter_nosig) begin
            r_no_signal <= 1'b1;
         end else if (w_leave_nosig) begin
            r_no_signal <= 1'b0;
         end
      end
   end

   assign bus.period    = r_period;
   assign bus.high_time = r_high_time;
   assign bus.valid     = r_valid;
   assign bus.no_signal = r_no_signal;
   assign bus.level     = r_s2;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: one wide-timeout instance for long periods,
// one TIMEOUT=100 instance for duty, timeout, recovery, boundary and reset cases.
module tb_pwm_capture;

   localparam int unsigned CW  = 32;
   localparam int unsigned T_S = 100;
   localparam int unsigned T_B = 20000;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pwm_capture_if #(.CNT_WIDTH(CW)) if_s ();
   pwm_capture_if #(.CNT_WIDTH(CW)) if_b ();

   pwm_capture #(.CNT_WIDTH(CW), .TIMEOUT(T_S)) u_dut_s (
      .clk (clk),
      .rst (rst),
      .bus (if_s.slave)
   );

   pwm_capture #(.CNT_WIDTH(CW), .TIMEOUT(T_B)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.slave)
   );

   int            n_checks  = 0;
   int            n_fail    = 0;
   int            n_valid_s = 0;
   int            n_valid_b = 0;
   logic [CW-1:0] exp_p     = '0;
   logic [CW-1:0] exp_h     = '0;
   int            snap;
   int            cnt;
   int            first;
   logic          saw_ns;

   // Single comparison point for the whole bench
   task automatic chk(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Every valid pulse is compared against the currently expected measurement
   always @(negedge clk) begin
      #1;
      if (if_s.valid === 1'b1) begin
         n_valid_s++;
         chk("cap_period", if_s.period, exp_p);
         chk("cap_high", if_s.high_time, exp_h);
      end
      if (if_b.valid === 1'b1) begin
         n_valid_b++;
         chk("big_period", if_b.period, CW'(10002));
         chk("big_high", if_b.high_time, CW'(5001));
      end
   end

   initial begin
      rst         = 1'b1;
      if_s.pwm_in = 1'b0;
      if_b.pwm_in = 1'b0;
      tick(3);
      rst = 1'b0;

      // Basic capture: toggle every 5001 cycles, three full periods
      snap = n_valid_b;
      for (int i = 0; i < 3 * 10002; i++) begin
         if_b.pwm_in = (i % 10002) < 5001;
         tick(1);
      end
      tick(5);
      chk("big_valid_cnt", CW'(n_valid_b - snap), CW'(2));
      chk("big_no_signal", CW'(if_b.no_signal), CW'(0));

      // Reset values (small instance has timed out by now)
      rst = 1'b1;
      tick(2);
      chk("rst_period", if_s.period, CW'(0));
      chk("rst_high", if_s.high_time, CW'(0));
      chk("rst_valid", CW'(if_s.valid), CW'(0));
      chk("rst_no_signal", CW'(if_s.no_signal), CW'(0));
      chk("rst_level", CW'(if_s.level), CW'(0));
      rst = 1'b0;

      // Duty 3/7: six periods, first rise only arms the measurement
      exp_p = 10;
      exp_h = 3;
      snap  = n_valid_s;
      for (int i = 0; i < 60; i++) begin
         if_s.pwm_in = (i % 10) < 3;
         tick(1);
      end
      chk("duty37_cnt", CW'(n_valid_s - snap), CW'(5));

      // Duty 1/1: first rise closes the last 3/7 period, then 2/1 every 2 cycles
      snap = n_valid_s;
      for (int i = 0; i < 44; i++) begin
         if_s.pwm_in = (i % 2) == 0;
         tick(1);
         if (i + 1 == 4) begin
            exp_p = 2;
            exp_h = 1;
         end
      end
      tick(5);
      chk("duty11_cnt", CW'(n_valid_s - snap), CW'(22));

      // Stuck high: rise closes a 7/1 period, then timeout 100 cycles after the detected rise
      exp_p       = 7;
      exp_h       = 1;
      snap        = n_valid_s;
      if_s.pwm_in = 1'b1;
      cnt         = 0;
      while (if_s.no_signal !== 1'b1 && cnt < 300) begin
         tick(1);
         cnt++;
         if (cnt == 2) chk("hi_level", CW'(if_s.level), CW'(1));
      end
      chk("hi_timeout_cycles", CW'(cnt), CW'(103));
      chk("hi_period_clr", if_s.period, CW'(0));
      chk("hi_high_clr", if_s.high_time, CW'(0));
      chk("hi_valid_cnt", CW'(n_valid_s - snap), CW'(1));
      tick(20);
      chk("hi_nosig_hold", CW'(if_s.no_signal), CW'(1));

      // Stuck low: one short pulse leaves NOSIG, then the input stays low
      if_s.pwm_in = 1'b0;
      tick(3);
      snap        = n_valid_s;
      if_s.pwm_in = 1'b1;
      tick(2);
      chk("lo_ns_before", CW'(if_s.no_signal), CW'(1));
      chk("lo_level", CW'(if_s.level), CW'(1));
      tick(1);
      chk("lo_ns_clear", CW'(if_s.no_signal), CW'(0));
      tick(1);
      cnt         = 4;
      if_s.pwm_in = 1'b0;
      while (if_s.no_signal !== 1'b1 && cnt < 300) begin
         tick(1);
         cnt++;
      end
      chk("lo_timeout_cycles", CW'(cnt), CW'(103));
      chk("lo_period_clr", if_s.period, CW'(0));
      chk("lo_high_clr", if_s.high_time, CW'(0));
      chk("lo_valid_cnt", CW'(n_valid_s - snap), CW'(0));

      // Recovery with a 4/4 square wave
      exp_p = 8;
      exp_h = 4;
      snap  = n_valid_s;
      for (int i = 0; i < 40; i++) begin
         if_s.pwm_in = (i % 8) < 4;
         tick(1);
         if (i == 1)  chk("rec_ns_hold", CW'(if_s.no_signal), CW'(1));
         if (i == 2)  chk("rec_ns_clear", CW'(if_s.no_signal), CW'(0));
         if (i == 9)  chk("rec_no_early_valid", CW'(if_s.valid), CW'(0));
         if (i == 10) chk("rec_first_valid", CW'(if_s.valid), CW'(1));
      end
      chk("rec_valid_cnt", CW'(n_valid_s - snap), CW'(4));

      // Boundary: period equal to TIMEOUT, high 40; first rise closes the last 4/4 period
      snap   = n_valid_s;
      saw_ns = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if_s.pwm_in = (i % 100) < 40;
         tick(1);
         if (i == 3) begin
            exp_p = 100;
            exp_h = 40;
         end
         if (if_s.no_signal === 1'b1) saw_ns = 1'b1;
      end
      chk("bnd_valid_cnt", CW'(n_valid_s - snap), CW'(3));
      chk("bnd_no_signal", CW'(saw_ns), CW'(0));

      // Reset during a HIGH phase
      if_s.pwm_in = 1'b1;
      tick(10);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_period", if_s.period, CW'(0));
      chk("mid_rst_high", if_s.high_time, CW'(0));
      chk("mid_rst_valid", CW'(if_s.valid), CW'(0));
      chk("mid_rst_no_signal", CW'(if_s.no_signal), CW'(0));
      chk("mid_rst_level", CW'(if_s.level), CW'(0));
      rst   = 1'b0;
      exp_p = 10;
      exp_h = 5;
      snap  = n_valid_s;
      first = 0;
      for (int i = 0; i < 20; i++) begin
         if_s.pwm_in = (i < 5) || (i >= 10 && i < 13);
         tick(1);
         if (if_s.valid === 1'b1 && first == 0) first = i + 1;
      end
      chk("mid_rst_first_valid", CW'(first), CW'(13));
      chk("mid_rst_valid_cnt", CW'(n_valid_s - snap), CW'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM or square-wave signal: it reports the period and high time of each complete cycle, in `clk` cycles. It is the receive-side counterpart of the `PWM` generator, used to close the loop on generated PWM and to read external PWM/tach inputs on the DE2 board. The asynchronous input is synchronised internally. After a configurable number of cycles with no rising edge, the block flags "no signal".

## Interface
- `CNT_WIDTH`, 32, width of the counters and of the `period`/`high_time` outputs.
- `TIMEOUT`, 1_000_000, cycles without a rising edge before `no_signal` is asserted. Must be ≥ 2 and < 2^CNT_WIDTH.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pwm_in`  in  1  asynchronous PWM input.
- `period`  out  CNT_WIDTH  last measured period, in clk cycles.
- `high_time`  out  CNT_WIDTH  last measured high time, in clk cycles.
- `valid`  out  1  one-cycle pulse when `period`/`high_time` update.
- `no_signal`  out  1  level flag: no rising edge for `TIMEOUT` cycles.
- `level`  out  1  synchronised copy of `pwm_in` (`s2`).

## Operation
- **Synchroniser:** `s1 <= pwm_in`, `s2 <= s1`, `s3 <= s2`.
  - rise = `s2 & ~s3`
  - fall = `~s2 & s3`
- **Counters:** `pcnt` (period) and `hcnt` (high).
  - On rise: `pcnt <= 1` and `hcnt <= 1`.
  - Otherwise `pcnt` increments each cycle, saturating at `TIMEOUT`.
  - `hcnt` increments only in state HIGH.
- **FSM states:** SYNC (reset state), HIGH, LOW, NOSIG.
  - **SYNC:**
    - rise → HIGH.
    - Partial cycles before the first rise are discarded.
    - `pcnt == TIMEOUT` with no rise → NOSIG.
  - **HIGH:**
    - fall → LOW, latching `hold_h <= hcnt`.
    - `pcnt == TIMEOUT` with no rise → NOSIG (stuck-high input).
  - **LOW:**
    - rise → HIGH with `period <= pcnt`, `high_time <= hold_h`, and `valid` = 1 for the next cycle.
    - `pcnt == TIMEOUT` with no rise → NOSIG (stuck-low input).
  - **NOSIG:**
    - `no_signal` = 1; `period` = 0 and `high_time` = 0.
    - rise → HIGH and `no_signal <= 0`. No capture occurs; the next complete cycle produces `valid`.
- **Simultaneous rise and `pcnt == TIMEOUT` in LOW:** the rise wins. Capture with `period = TIMEOUT`; no timeout.
- The first `valid` after SYNC or NOSIG requires a rise, a fall and another rise.
- Entering NOSIG clears `period` and `high_time` to 0 in the same update. `valid` is not pulsed.
- **Reset:** may occur mid-measurement. The next cycle shows the reset values:
  - state SYNC
  - `period` = 0, `high_time` = 0, `valid` = 0, `no_signal` = 0, `level` = 0
  - `s1`/`s2`/`s3` = 0, counters = 0
- Counters never wrap, so no result can be larger than `TIMEOUT`.

## Timing
- Edge-detect latency: a `pwm_in` transition sampled at edge k is seen as rise/fall in the cycle after edge k+1.
- A clean input with period P and high time H (in clk cycles, P ≤ `TIMEOUT`) measures exactly `period` = P and `high_time` = H.
- `valid` rises 1 cycle after the detected closing rise: about 3 clk cycles after the `pwm_in` edge, counting synchroniser and register.
- `valid` is high for exactly 1 cycle. `period`/`high_time` change only on that cycle, on entry to NOSIG, or on reset, and hold otherwise.
- `no_signal` asserts `TIMEOUT` cycles after the last detected rise, or after leaving reset / starting SYNC.
- Minimum measurable high or low phase: 1 cycle. Pulses shorter than 1 clk may be missed; this is acceptable.

## Test plan
- **Basic capture:** drive from `PWM` with `PWM_FREQ` = 5000 (toggles every 5001 clk cycles) → from the second rise on, every `valid` shows `period` = 10002 and `high_time` = 5001.
- **Duty variation:** high 3 / low 7 clk, repeating → `period` = 10, `high_time` = 3. Switch to high 1 / low 1 → `period` = 2, `high_time` = 1, with `valid` every 2 cycles.
- **Timeout:** `TIMEOUT` = 100; hold `pwm_in` high after a rise → `no_signal` = 1 exactly 100 cycles after the detected rise, `period` = `high_time` = 0, no `valid`. Repeat with the input stuck low.
- **Recovery:** from NOSIG, apply 4/4 square wave → `no_signal` clears on the first detected rise. First `valid` comes one full period later with `period` = 8, `high_time` = 4.
- **Boundary:** `TIMEOUT` = 100 and period exactly 100 (high 40) → `valid` with `period` = 100, `high_time` = 40, and `no_signal` stays 0.
- **Reset mid-measurement:** assert `rst` for 1 cycle during a HIGH phase → all outputs are 0 the following cycle. The first `valid` comes only after a full rise-fall-rise.
